// File: rtl/led_fx_pkg.sv
// rtl/led_fx_pkg.sv - shared brightness/decay parameters and types for LED effects
package led_fx_pkg;

  localparam int LVL_BITS_DEF  = 4;
  localparam int DECAY_DIV_DEF = 500000;

  function automatic int lvl_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  localparam int LVL_MAX_DEF = lvl_max(LVL_BITS_DEF);

  typedef logic [LVL_BITS_DEF-1:0] level_t;

endpackage

// File: rtl/led_pwm_chan.sv
// rtl/led_pwm_chan.sv - one afterglow channel: level register, decay, PWM compare
module led_pwm_chan
  import led_fx_pkg::*;
#(
  parameter int LVL_BITS = LVL_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_bit,
  input  logic                decay_tick,
  input  logic [LVL_BITS-1:0] pwm_cnt,
  output logic                out_bit
);

  localparam logic [LVL_BITS-1:0] LVL_MAX = LVL_BITS'(lvl_max(LVL_BITS));

  logic [LVL_BITS-1:0] level;

  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      out_bit <= 1'b0;
    end else if (!en) begin
      level   <= in_bit ? LVL_MAX : '0;
      out_bit <= in_bit;
    end else begin
      // A lit input re-arms even on a tick cycle; decay never wraps below zero.
      if (in_bit)
        level <= LVL_MAX;
      else if (decay_tick && (level != '0))
        level <= level - 1'b1;
      out_bit <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_afterglow.sv
// rtl/led_afterglow.sv - per-LED fading trail with PWM drive and registered bypass
module led_afterglow
  import led_fx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LVL_BITS  = LVL_BITS_DEF,
  parameter int DECAY_DIV = DECAY_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] led_in,
  output logic [WIDTH-1:0] led_out,
  output logic             decay_tick
);

  localparam int                  DW    = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0]       DLAST = DW'(DECAY_DIV - 1);
  localparam logic [LVL_BITS-1:0] PLAST = LVL_BITS'(lvl_max(LVL_BITS) - 1);

  logic [LVL_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       dcnt;

  // Both counters park at zero while bypassed so re-enable starts a clean frame.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pwm_cnt <= '0;
      dcnt    <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == PLAST) ? '0 : pwm_cnt + 1'b1;
      dcnt    <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
    end
  end

  assign decay_tick = en && !rst && (dcnt == DLAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    led_pwm_chan #(
      .LVL_BITS(LVL_BITS)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_bit    (led_in[i]),
      .decay_tick(decay_tick),
      .pwm_cnt   (pwm_cnt),
      .out_bit   (led_out[i])
    );
  end

endmodule

// File: doc/led_afterglow.md
# led_afterglow

Per-LED afterglow stage placed between the rotating LED pattern generator and the NVBoard LED pins. It takes the 16-bit on/off pattern and produces PWM-driven outputs. A lit input holds its LED at full brightness. When the input drops, the brightness decays stepwise to dark, leaving a fading trail behind the rotating bit. A bypass mode passes the pattern through unchanged.

## Interface
- `WIDTH`, 16: number of LED channels.
- `LVL_BITS`, 4: brightness level width. `LVL_MAX = 2**LVL_BITS-1` (15).
- `DECAY_DIV`, 500000: clock cycles between decay steps. Must be ≥ 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active high.
- `en` in 1: 1 = afterglow/PWM mode; 0 = registered bypass.
- `led_in` in WIDTH: on/off pattern from the upstream generator, same clock domain.
- `led_out` out WIDTH: registered drive to the board LEDs.
- `decay_tick` out 1: one-cycle pulse marking a decay step (status/debug).

## Operation
- `pwm_cnt` (LVL_BITS): counts 0..LVL_MAX-1, then wraps to 0. PWM period is LVL_MAX cycles (15).
- `dcnt` (ceil log2 DECAY_DIV bits): counts 0..DECAY_DIV-1, then wraps.
  - `decay_tick = en && (dcnt == DECAY_DIV-1)`; combinational from `dcnt`.
- Per channel i, `level[i]` (LVL_BITS):
  - `en=1`, `led_in[i]=1`: `level <= LVL_MAX`. Load wins over a simultaneous decay_tick.
  - `en=1`, `led_in[i]=0`, decay_tick: `level <= level-1`, saturating at 0. No wrap from 0 to LVL_MAX.
  - `en=1`, otherwise: hold.
  - `en=0`: `level <= led_in[i] ? LVL_MAX : 0`.
- Output, per channel:
  - `en=1`: `led_out[i] <= (level[i] > pwm_cnt)`. Duty is level/15; level 15 is steady on, level 0 is steady off.
  - `en=0`: `led_out[i] <= led_in[i]`.
- `en=0` also holds `pwm_cnt` and `dcnt` at 0, so re-enabling starts a clean frame and a full decay interval.
- Full fade from LVL_MAX to 0 takes 15 decay ticks (15·DECAY_DIV cycles). Decay phase is global; a channel's first step lands on the next shared tick, not DECAY_DIV cycles after its input fell.

## Timing
- Reset: `level`=0, `pwm_cnt`=0, `dcnt`=0, `led_out`=0, `decay_tick`=0. No output glitch on the cycle `rst` is high.
- Reset mid-fade: all trails cleared on the next edge. The first decay_tick after reset release comes DECAY_DIV cycles later.
- Latency with `en=1`:
  - `led_in` rise sampled at edge k → `level`=15 after edge k → `led_out` high after edge k+1.
  - This is 2 edges and constant, since level 15 exceeds every `pwm_cnt` value.
- Latency with `en=0`: 1 edge, input to output.
- `en` 1→0 mid-fade: levels snap to `led_in` at the next edge and `led_out` equals `led_in` from that edge on. Trails are dropped.
- `en` 0→1: `pwm_cnt` and `dcnt` start at 0 on the first enabled cycle.
- `led_in` toggling faster than DECAY_DIV re-arms to LVL_MAX each time it is 1. There is no accumulation.

## Structure
- Package `led_fx_pkg` holds:
  - `LVL_BITS` default and the `LVL_MAX` function/constant.
  - A `level_t` typedef.
  - The `DECAY_DIV` default.
- Sub-module `led_pwm_chan`: one channel (level register, load/decay/saturate logic, compare, output flop).
  - Inputs: `clk`, `rst`, `en`, `in_bit`, `decay_tick`, `pwm_cnt`.
  - Output: `out_bit`.
  - Generated WIDTH times.
- The top level owns `pwm_cnt`, `dcnt` and `decay_tick`.

## Test plan
All scenarios use `DECAY_DIV=4`, `WIDTH=16`.
- **Reset:** `rst`=1 for 3 cycles with `led_in`=16'hFFFF → `led_out`=0 and `decay_tick`=0 throughout. After release, `led_out`=16'hFFFF 2 edges later.
- **Steady full:** `en`=1, `led_in`=16'h0001 held for 60 cycles → `led_out[0]`=1 every cycle and `led_out[15:1]`=0.
- **Fade:** drop `led_in[0]` to 0.
  - `level[0]` steps 15→14→…→0 on successive decay_ticks, 4 cycles apart, then stays at 0.
  - Over one 15-cycle frame at level 7, `led_out[0]` is high for exactly 7 cycles.
  - After the 15th tick, `led_out[0]`=0.
- **Collision:** raise `led_in[3]` in the same cycle `decay_tick`=1 while `level[3]`=5 → `level[3]`=15 next cycle.
- **Bypass:** `en`=0 with `led_in` rotating 16'h0001→16'h0002→16'h0004 → `led_out` equals `led_in` delayed 1 edge; no trail remains after `en`=0 takes effect.
- **Reset mid-fade:** `rst` pulse at `level[0]`=9 → all levels 0 and `led_out`=0 next edge. First `decay_tick` occurs 4 cycles after release.
